// File: rtl/processor_pkg.sv
// +----------------------------------------------------------------------------+
// | processor_pkg : shared constants for the data-memory responder slice        |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package processor_pkg;
    localparam int          c_DATA_W    = 32;
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_WAIT   = 2'd1;
    localparam logic [1:0]  c_ST_RESP   = 2'd2;
    // Load data returned alongside a rejected access.
    localparam logic [c_DATA_W-1:0] c_ERR_RDATA = '0;
endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// +----------------------------------------------------------------------------+
// | dmem_responder_if : core <-> data-memory request/ack bus                    |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
    import processor_pkg::*;

    logic                MemReq;
    logic                MemWrite;
    logic [c_DATA_W-1:0] Addr;
    logic [c_DATA_W-1:0] WriteData;
    logic [c_DATA_W-1:0] ReadData;
    logic                MemAck;
    logic                MemErr;

    modport master (
        output MemReq, MemWrite, Addr, WriteData,
        input  ReadData, MemAck, MemErr
    );

    modport slave (
        input  MemReq, MemWrite, Addr, WriteData,
        output ReadData, MemAck, MemErr
    );
endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// +----------------------------------------------------------------------------+
// | dmem_array : DEPTH x 32 storage, synchronous write, registered read,        |
// |              asynchronous clear of every word and the read register         |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_array
    import processor_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_we,
    input  wire                 i_re,
    input  wire                 i_rd_zero,
    input  wire  [AW-1:0]       i_idx,
    input  wire  [c_DATA_W-1:0] i_wdata,
    output logic [c_DATA_W-1:0] o_rdata
);
    logic [c_DATA_W-1:0] r_mem [DEPTH];
    logic [c_DATA_W-1:0] r_rdata;

    // Read register only updates on a load, so it holds across store acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= i_rd_zero ? c_ERR_RDATA : r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +----------------------------------------------------------------------------+
// | dmem_responder : data-memory responder with req/ack handshake, programmable |
// |                  wait states and misaligned/out-of-range rejection          |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_responder
    import processor_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  wire            Clk,
    input  wire            Rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic                r_err;
    logic [AW-1:0]       r_idx;
    logic [c_DATA_W-1:0] r_wdata;

    logic [32:0]         w_diff;
    logic                w_err;
    logic [AW-1:0]       w_idx;
    logic                w_cap;
    logic                w_enter_resp;
    logic                w_cur_write;
    logic                w_cur_err;
    logic [AW-1:0]       w_cur_idx;
    logic [c_DATA_W-1:0] w_cur_wdata;
    logic [c_DATA_W-1:0] w_rdata;

    // Bit 32 of the widened difference flags an address below BASE_ADDR.
    assign w_diff = {1'b0, bus.Addr} - {1'b0, BASE_ADDR};
    assign w_err  = (w_diff[1:0] != 2'b00) | w_diff[32] | (w_diff[31:2] >= 30'(DEPTH));
    assign w_idx  = w_diff[AW+1:2];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.MemReq) w_next = (WAIT_STATES == 0) ? c_ST_RESP : c_ST_WAIT;
            c_ST_WAIT: if (r_cnt == 4'd1) w_next = c_ST_RESP;
            c_ST_RESP: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (r_state == c_ST_IDLE && bus.MemReq) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_write <= bus.MemWrite;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= bus.WriteData;
        end else if (r_state == c_ST_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // With zero wait states RESP is entered on the capture edge itself,
    // so the array must see the live bus rather than the latched copy.
    assign w_cap        = (r_state == c_ST_IDLE);
    assign w_enter_resp = (w_next == c_ST_RESP) && (r_state != c_ST_RESP);
    assign w_cur_write  = w_cap ? bus.MemWrite  : r_write;
    assign w_cur_err    = w_cap ? w_err         : r_err;
    assign w_cur_idx    = w_cap ? w_idx         : r_idx;
    assign w_cur_wdata  = w_cap ? bus.WriteData : r_wdata;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (Clk),
        .rst       (Rst),
        .i_we      (w_enter_resp & w_cur_write & ~w_cur_err),
        .i_re      (w_enter_resp & ~w_cur_write),
        .i_rd_zero (w_cur_err),
        .i_idx     (w_cur_idx),
        .i_wdata   (w_cur_wdata),
        .o_rdata   (w_rdata)
    );

    always_comb begin
        bus.MemAck = (r_state == c_ST_RESP);
        bus.MemErr = (r_state == c_ST_RESP) & r_err;
    end

    assign bus.ReadData = w_rdata;
endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_responder : directed self-checking bench, WAIT_STATES=2 and 0       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(64), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus2)
    );

    dmem_responder #(.DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .Clk (clk),
        .Rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input bit req, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            bus0.MemReq = req; bus0.MemWrite = wr; bus0.Addr = a; bus0.WriteData = wd;
        end else begin
            bus2.MemReq = req; bus2.MemWrite = wr; bus2.Addr = a; bus2.WriteData = wd;
        end
    endtask

    // One transaction; lat counts negedges after the capture edge until MemAck (-1 = timeout).
    task automatic xact(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, a, wd);
        @(posedge clk);
        lat = -1; rd = 'x; er = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel ? bus0.MemAck : bus2.MemAck) === 1'b1) begin
                lat = i;
                rd  = sel ? bus0.ReadData : bus2.ReadData;
                er  = sel ? bus0.MemErr : bus2.MemErr;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({bus2.MemAck, bus2.MemErr, bus2.ReadData} !== 34'h0) begin
            n_errors++; $display("FAIL reset_active: got ack=%b err=%b rd=%h required 0 0 0", bus2.MemAck, bus2.MemErr, bus2.ReadData);
        end
        @(posedge clk); #25;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.MemAck !== 1'b0 || bus2.MemErr !== 1'b0) begin
                n_errors++; $display("FAIL idle_ack_err cyc %0d: got ack=%b err=%b required 0 0", i, bus2.MemAck, bus2.MemErr);
            end
            n_checks++;
            if (bus2.ReadData !== 32'h0) begin
                n_errors++; $display("FAIL idle_rdata cyc %0d: got %h required 00000000", i, bus2.ReadData);
            end
            n_checks++;
            if (bus0.MemAck !== 1'b0) begin
                n_errors++; $display("FAIL idle_ack_ws0 cyc %0d: got %b required 0", i, bus0.MemAck);
            end
        end
    endtask

    task automatic test_store_load;
        int lat; logic [31:0] rd; logic er;
        xact(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, lat, rd, er);
        n_checks++;
        if (lat !== 3 || er !== 1'b0) begin
            n_errors++; $display("FAIL store_ack: got lat=%0d err=%b required 3 0", lat, er);
        end
        n_checks++;
        if (rd !== 32'h0) begin
            n_errors++; $display("FAIL store_rdata_hold: got %h required 00000000", rd);
        end
        @(negedge clk);
        n_checks++;
        if (bus2.MemAck !== 1'b0) begin
            n_errors++; $display("FAIL ack_pulse_width: got ack=%b required 0", bus2.MemAck);
        end
        xact(1'b0, 1'b0, 32'h8, 32'h0, lat, rd, er);
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL load_8: got lat=%0d err=%b rd=%h required 3 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic er;
        xact(1'b0, 1'b1, 32'h6, 32'h1234, lat, rd, er);
        n_checks++;
        if (lat !== 3 || er !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_store: got lat=%0d err=%b required 3 1", lat, er);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL err_store_rdata_hold: got %h required deadbeef", rd);
        end
        xact(1'b0, 1'b0, 32'h4, 32'h0, lat, rd, er);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            n_errors++; $display("FAIL load_4_after_bad_store: got err=%b rd=%h required 0 00000000", er, rd);
        end
        xact(1'b0, 1'b0, 32'h100, 32'h0, lat, rd, er);
        n_checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
            n_errors++; $display("FAIL out_of_range_load: got lat=%0d err=%b rd=%h required 3 1 00000000", lat, er, rd);
        end
        xact(1'b0, 1'b0, 32'hFC, 32'h0, lat, rd, er);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            n_errors++; $display("FAIL last_word_load: got err=%b rd=%h required 0 00000000", er, rd);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er;
        xact(1'b1, 1'b1, 32'h0, 32'h11111111, lat, rd, er);
        n_checks++;
        if (lat !== 1 || er !== 1'b0) begin
            n_errors++; $display("FAIL ws0_store: got lat=%0d err=%b required 1 0", lat, er);
        end
        xact(1'b1, 1'b1, 32'h4, 32'h22222222, lat, rd, er);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus0.MemAck !== 1'b1 || bus0.ReadData !== 32'h11111111) begin
            n_errors++; $display("FAIL b2b_first: got ack=%b rd=%h required 1 11111111", bus0.MemAck, bus0.ReadData);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus0.MemAck !== 1'b0) begin
            n_errors++; $display("FAIL b2b_gap: got ack=%b required 0", bus0.MemAck);
        end
        @(negedge clk);
        n_checks++;
        if (bus0.MemAck !== 1'b1 || bus0.ReadData !== 32'h22222222 || bus0.MemErr !== 1'b0) begin
            n_errors++; $display("FAIL b2b_second: got ack=%b err=%b rd=%h required 1 0 22222222", bus0.MemAck, bus0.MemErr, bus0.ReadData);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic er;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'hC, 32'hAAAA5555);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.MemAck !== 1'b0) begin
                n_errors++; $display("FAIL abort_no_ack cyc %0d: got ack=%b required 0", i, bus2.MemAck);
            end
        end
        xact(1'b0, 1'b0, 32'hC, 32'h0, lat, rd, er);
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            n_errors++; $display("FAIL load_c_after_abort: got lat=%0d err=%b rd=%h required 3 0 00000000", lat, er, rd);
        end
    endtask

    task automatic test_held_req;
        int lat; logic [31:0] rd; logic er; logic [31:0] rd1;
        xact(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, lat, rd, er);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus2.MemAck === 1'b1) begin lat = i; break; end
        end
        rd1 = bus2.ReadData;
        n_checks++;
        if (lat !== 3 || rd1 !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL held_first: got lat=%0d rd=%h required 3 cafef00d", lat, rd1);
        end
        @(posedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus2.MemAck === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 3 || bus2.ReadData !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL held_repeat: got lat=%0d rd=%h required 3 cafef00d", lat, bus2.ReadData);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_held_req();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
